// File: rtl/telemetry_framer_pkg.sv
// rtl/telemetry_framer_pkg.sv - shared state encoding, frame constants and ASCII helper for telemetry_framer
package telemetry_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } frame_state_t;

   localparam logic [7:0] TELEM_HEADER    = 8'hAA;
   localparam int         FRAME_LEN_BIN   = 6;
   localparam int         FRAME_LEN_ASCII = 10;
   localparam logic [7:0] ASCII_CR        = 8'h0D;
   localparam logic [7:0] ASCII_LF        = 8'h0A;

   // Uppercase hex digit for one nibble: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46
   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      logic [7:0] wide;
      wide = {4'h0, nib};
      if (nib < 4'd10) begin
         return 8'h30 + wide;
      end
      return 8'h37 + wide;
   endfunction

endpackage

// File: rtl/telemetry_framer_tick_gen.sv
// rtl/telemetry_framer_tick_gen.sv - free-running period counter producing a one-cycle frame tick
module telemetry_framer_tick_gen #(
   parameter int PERIOD_CYC = 5_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD_CYC - 1);

   logic [CW-1:0] cnt;

   // Count 0..PERIOD_CYC-1 forever; enable gating happens downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - periodic framed telemetry byte source for the UART transmitter (TELEM_ASCII_EN selects ASCII hex frames)
module telemetry_framer
   import telemetry_framer_pkg::*;
#(
   parameter int         CLK_HZ     = 50_000_000,
   parameter int         BAUD       = 9600,
   parameter int         PERIOD_CYC = 5_000_000,
   parameter logic [7:0] HEADER     = TELEM_HEADER
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] num,
   input  logic        en,
   output logic [7:0]  data,
   output logic        start,
   output logic        busy,
   output logic        frame_done
);

   // One byte slot: 10 bit times plus one guard bit so tx is never overrun
   localparam int            BYTE_CYC = (CLK_HZ / BAUD) * 11;
   localparam int            GW       = $clog2(BYTE_CYC);
   localparam logic [GW-1:0] GAP_LAST = GW'(BYTE_CYC - 2);

`ifdef TELEM_ASCII_EN
   localparam int FRAME_LEN = FRAME_LEN_ASCII;
`else
   localparam int FRAME_LEN = FRAME_LEN_BIN;
`endif
   localparam logic [3:0] IDX_LAST = 4'(FRAME_LEN - 1);

   frame_state_t  state;
   logic [3:0]    idx;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   shadow;
   logic          pending;
   logic          tick;
   logic          launch;

   telemetry_framer_tick_gen #(
      .PERIOD_CYC (PERIOD_CYC)
   ) u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Byte i of the frame built from the snapshot value v
   function automatic logic [7:0] frame_byte(input logic [31:0] v, input logic [3:0] i);
      logic [31:0] sh;
      logic [7:0]  b;
      b = 8'h00;
`ifdef TELEM_ASCII_EN
      sh = v << {i[2:0], 2'b00};
      if (i < 4'd8) begin
         b = nibble_to_ascii(sh[31:28]);
      end else if (i == 4'd8) begin
         b = ASCII_CR;
      end else if (i == 4'd9) begin
         b = ASCII_LF;
      end
`else
      sh = v;
      case (i)
         4'd0:    b = HEADER;
         4'd1:    b = sh[31:24];
         4'd2:    b = sh[23:16];
         4'd3:    b = sh[15:8];
         4'd4:    b = sh[7:0];
         4'd5:    b = HEADER ^ sh[31:24] ^ sh[23:16] ^ sh[15:8] ^ sh[7:0];
         default: b = 8'h00;
      endcase
`endif
      return b;
   endfunction

   // A frame may only start from IDLE, and only while framing is enabled
   assign launch = (state == ST_IDLE) && pending && en;

   // Single-entry request queue: ticks arriving while a request waits are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if ((state == ST_IDLE) && (launch || !en)) begin
         pending <= 1'b0;
      end else if (tick && en) begin
         pending <= 1'b1;
      end
   end

   // Frame sequencer with registered outputs; start lands in the SEND cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         idx        <= 4'd0;
         gap_cnt    <= '0;
         shadow     <= 32'h0;
         data       <= 8'h00;
         start      <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         start      <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  shadow <= num;
                  idx    <= 4'd0;
                  busy   <= 1'b1;
                  state  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               data  <= frame_byte(shadow, idx);
               start <= 1'b1;
               state <= ST_SEND;
            end
            ST_SEND: begin
               gap_cnt <= '0;
               state   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (idx == IDX_LAST) begin
                     frame_done <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     idx   <= idx + 4'd1;
                     data  <= frame_byte(shadow, idx + 4'd1);
                     start <= 1'b1;
                     state <= ST_SEND;
                  end
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            ST_DONE: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
